// File: rtl/stick_tx_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stick_tx_rx : framed stream receiver with payload FIFO and per-frame status.
// Optional macro STICK_RX_CSUM_EN adds an XOR checksum trailer word. Rev 1.0
// ----------------------------------------------------------------------------
module stick_tx_rx #(
   parameter int          DATA_W    = 32,
   parameter int          FIFO_AW   = 4,
   parameter int          TIMEOUT   = 1000,
   parameter logic [15:0] HDR_MAGIC = 16'hA5C3
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_vld,
   output logic              o_tx_rdy,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_vld,
   input  logic              i_rd_ack,
   output logic              o_frame_ok,
   output logic              o_frame_err,
   output logic [15:0]       o_frame_cnt,
   output logic [FIFO_AW:0]  o_fill
);

   localparam int                 C_DEPTH    = 2**FIFO_AW;
   localparam int                 C_GAP_W    = $clog2(TIMEOUT + 1);
   localparam logic [C_GAP_W-1:0] C_TIMEOUT  = C_GAP_W'(TIMEOUT);
   localparam logic [C_GAP_W-1:0] C_GAP_ONE  = C_GAP_W'(1);
   localparam logic [FIFO_AW:0]   C_RDY_MAX  = (FIFO_AW + 1)'(C_DEPTH - 2);
   localparam logic [FIFO_AW:0]   C_FILL_ONE = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] C_PTR_ONE  = FIFO_AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
`ifdef STICK_RX_CSUM_EN
      ST_CSUM    = 2'd3,
`endif
      ST_DONE    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         rem_q, rem_d;
   logic [DATA_W-1:0]   csum_q, csum_d;
   logic [C_GAP_W-1:0]  gap_q, gap_d;
   logic                rdy_q, rdy_d;
   logic                ok_q, ok_d;
   logic                err_q, err_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]    fill_q, fill_d;
   logic [DATA_W-1:0]   mem_q [C_DEPTH];

   logic                w_acc;
   logic                w_push;
   logic                w_pop;
   logic                w_gap_hit;
   logic [C_GAP_W-1:0]  w_gap_inc;

   assign w_acc     = i_tx_vld && rdy_q;
   assign w_pop     = i_rd_ack && (fill_q != '0);
   assign w_gap_inc = gap_q + C_GAP_ONE;
   assign w_gap_hit = (w_gap_inc == C_TIMEOUT);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      csum_d  = csum_q;
      gap_d   = gap_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      w_push  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            gap_d = '0;
            if (w_acc) begin
               if (i_tx_data[31:16] == HDR_MAGIC) begin
                  rem_d  = i_tx_data[15:0];
                  csum_d = '0;
                  if (i_tx_data[15:0] != 16'd0) begin
                     state_d = ST_PAYLOAD;
                  end else begin
`ifdef STICK_RX_CSUM_EN
                     state_d = ST_CSUM;
`else
                     state_d = ST_DONE;
`endif
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (w_acc) begin
               w_push = 1'b1;
               csum_d = csum_q ^ i_tx_data;
               rem_d  = rem_q - 16'd1;
               gap_d  = '0;
               if (rem_q == 16'd1) begin
`ifdef STICK_RX_CSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end
            end else if (w_gap_hit) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               gap_d = w_gap_inc;
            end
         end
`ifdef STICK_RX_CSUM_EN
         ST_CSUM: begin
            if (w_acc) begin
               gap_d = '0;
               if (i_tx_data == csum_q) begin
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (w_gap_hit) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               gap_d = w_gap_inc;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status is registered so it shows during the single DONE cycle.
      if (state_d == ST_DONE) begin
         ok_d  = 1'b1;
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_comb begin
      fill_d = fill_q;
      case ({w_push, w_pop})
         2'b10:   fill_d = fill_q + C_FILL_ONE;
         2'b01:   fill_d = fill_q - C_FILL_ONE;
         default: fill_d = fill_q;
      endcase
      rdy_d = (state_d != ST_DONE) && (fill_d <= C_RDY_MAX);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         csum_q   <= '0;
         gap_q    <= '0;
         rdy_q    <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         csum_q  <= csum_d;
         gap_q   <= gap_d;
         rdy_q   <= rdy_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         if (w_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_push) mem_q[wr_ptr_q] <= i_tx_data;
   end

   // Head word is masked while empty so stale storage never leaks out.
   assign o_rd_vld    = (fill_q != '0);
   assign o_rd_data   = o_rd_vld ? mem_q[rd_ptr_q] : '0;
   assign o_tx_rdy    = rdy_q;
   assign o_frame_ok  = ok_q;
   assign o_frame_err = err_q;
   assign o_frame_cnt = cnt_q;
   assign o_fill      = fill_q;

endmodule
`default_nettype wire
